reciever_event_packer: RTL and testbench
========================================

// Module: reciever_event_packer
//
// PURPOSE
//  Downstream stage of the receiver encoding stage. Consumes the registered
//  symbol and pulse_detected strobe each clk cycle and timestamps every
//  detection with a free-running slot counter. Buffers {slot, symbol} records
//  in a FIFO and presents them on a valid/ready stream to the sifting/readout
//  logic.
//
// PARAMETERS
//  SLOT_W      16  width of slot counter and of the timestamp field
//  FIFO_DEPTH  16  record buffer depth; must be a power of 2, >= 2
//  DEAD_CYCLES 4   detector dead time in clk cycles (DEAD_TIME_EN only), >= 1
//
// PORTS
//  clk            in   1                     system clock, all logic on posedge
//  rst            in   1                     synchronous, active-high reset
//  run            in   1                     1 = acquisition active
//  symbol_in      in   2                     symbol from the encoding stage
//  pulse_detected in   1                     detection strobe, aligned with symbol_in
//  m_data         out  SLOT_W+2              record {slot[SLOT_W-1:0], symbol[1:0]}
//  m_valid        out  1                     m_data holds a valid record
//  m_ready        in   1                     consumer accepts record when m_valid & m_ready
//  fifo_level     out  $clog2(FIFO_DEPTH)+1  records currently buffered
//  overflow_cnt   out  16                    records dropped on full FIFO, saturating
//  slot_count     out  SLOT_W                current slot counter value
//
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): slot_count=0, fifo_level=0, m_valid=0,
//    m_data=0, overflow_cnt=0, run history=0, dead-time counter=0. Reset
//    mid-operation discards all buffered records.
//  - Slot counter:
//    - Cleared to 0 on the cycle after run rises 0->1.
//    - Otherwise increments by 1 every cycle while run=1; wraps 2^SLOT_W-1 -> 0.
//    - Holds while run=0.
//  - Capture: a cycle with run=1 and pulse_detected=1 is an event. Its record
//    is {slot_count as seen in that cycle, symbol_in}.
//  - Write rule:
//    - Event written if fifo_level < FIFO_DEPTH, or if FIFO is full and a pop
//      (m_valid & m_ready) occurs in the same cycle.
//    - Otherwise the event is dropped and overflow_cnt increments, saturating
//      at 16'hFFFF.
//  - Events with run=0 are ignored and not counted.
//  - Read side is first-word-fall-through:
//    - m_valid = (fifo_level != 0); m_data = oldest record.
//    - m_data is stable while m_valid=1 and m_ready=0.
//    - Latency: event in cycle N -> m_valid=1 with that record in cycle N+1
//      (FIFO previously empty).
//  - Simultaneous push and pop: fifo_level unchanged, order preserved.
//  - run=0 does not stop reads; buffered records drain normally.
//  - Pointers wrap modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH.
//
// CONFIGURATION
//  DEAD_TIME_EN defined:
//    - Once an event is taken (written or dropped), pulse_detected is ignored
//      for the next DEAD_CYCLES cycles.
//    - Ignored pulses are neither written nor counted in overflow_cnt.
//    - Dead-time counter is cleared by rst and while run=0.
//  DEAD_TIME_EN undefined:
//    - Every cycle with run=1 and pulse_detected=1 is an event.
//    - No dead-time logic is synthesised.
//
// TESTING
//  1. rst 1 cycle -> all outputs 0; m_valid=0; slot_count stays 0 while run=0.
//  2. run rises, pulse at slot 5 sym=1 -> next cycle m_valid=1,
//     m_data={16'd5,2'b01}; m_ready=1 -> fifo_level=0.
//  3. m_ready=0, 18 consecutive pulses (DEPTH=16) -> fifo_level=16,
//     overflow_cnt=2; drain -> slots n..n+15 in order.
//  4. FIFO full, pulse and pop in the same cycle -> level stays 16,
//     overflow_cnt unchanged, new record last.
//  5. SLOT_W=4, run held 20 cycles with pulses at slots 15 and 16 ->
//     timestamps 15 then 0.
//  6. DEAD_TIME_EN, DEAD_CYCLES=4, pulses every cycle for 10 cycles ->
//     records at cycles 0, 5 only; overflow_cnt=0.

Source files
------------

// File: rtl/reciever_event_packer.sv
// Timestamps receiver detections with a free-running slot counter and queues {slot, symbol} records.
// Latency: event in cycle N is visible on m_data/m_valid in cycle N+1 (FWFT, FIFO previously empty).
// Backpressure: m_ready low holds records in the FIFO; events arriving while full are dropped and counted.
// Optional build macro DEAD_TIME_EN adds a detector dead time of DEAD_CYCLES cycles after each event.
module reciever_event_packer #(
    parameter int SLOT_W      = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic [1:0]                    symbol_in,
    input  logic                          pulse_detected,
    output logic [SLOT_W+1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overflow_cnt,
    output logic [SLOT_W-1:0]             slot_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = SLOT_W + 2;

    logic [RW-1:0]     mem_q [FIFO_DEPTH];
    logic [RW-1:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [15:0]       ovf_q, ovf_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              run_q, run_d;

    logic event_vld;
    logic full;
    logic pop;
    logic push;
    logic drop;

`ifdef DEAD_TIME_EN
    localparam int DW = $clog2(DEAD_CYCLES + 1);

    logic [DW-1:0] dead_q, dead_d;

    assign event_vld = run & pulse_detected & (dead_q == '0);

    // Dead-time countdown: armed by any taken event (written or dropped), idle while run is low
    always_comb begin
        dead_d = dead_q;
        if (!run) begin
            dead_d = '0;
        end else if (event_vld) begin
            dead_d = DW'(DEAD_CYCLES);
        end else if (dead_q != '0) begin
            dead_d = dead_q - DW'(1);
        end
    end

    // Dead-time counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            dead_q <= '0;
        end else begin
            dead_q <= dead_d;
        end
    end
`else
    assign event_vld = run & pulse_detected;
`endif

    assign m_valid      = (level_q != '0);
    assign full         = (level_q == LW'(FIFO_DEPTH));
    assign pop          = m_valid & m_ready;
    // A full FIFO still accepts an event when the head leaves in the same cycle
    assign push         = event_vld & (~full | pop);
    assign drop         = event_vld & full & ~pop;
    // Empty FIFO presents zero rather than a stale entry
    assign m_data       = m_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level   = level_q;
    assign overflow_cnt = ovf_q;
    assign slot_count   = slot_q;

    // Next-state for slot counter, run history, pointers, level and drop counter
    always_comb begin
        run_d    = run;
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (run && !run_q) begin
            slot_d = '0;
        end else if (run) begin
            slot_d = slot_q + SLOT_W'(1);
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    // Record storage write: the record carries the slot value seen in the event cycle
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {slot_q, symbol_in};
        end
    end

    // Control registers with synchronous reset; reset discards buffered records
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= 1'b0;
            slot_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            run_q    <= run_d;
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Record storage register; contents are only observable through level_q so no reset is needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_reciever_event_packer.sv
module tb_reciever_event_packer;

    localparam int DEPTH = 16;
    localparam int DEAD  = 4;
`ifdef DEAD_TIME_EN
    localparam int WRAP_SECOND = 15 + DEAD + 1;
`else
    localparam int WRAP_SECOND = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [1:0]  symbol_in;
    logic        pulse_detected;
    logic        m_ready;

    logic [17:0] m_data;
    logic        m_valid;
    logic [4:0]  fifo_level;
    logic [15:0] overflow_cnt;
    logic [15:0] slot_count;

    logic [5:0]  m_data4;
    logic        m_valid4;
    logic [4:0]  fifo_level4;
    logic [15:0] overflow_cnt4;
    logic [3:0]  slot_count4;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [17:0] mq[$];
    logic [15:0] m_slot;
    bit          m_run_hist;
    int          m_ovf;
    int          m_dead;

    always #5 clk = ~clk;

    reciever_event_packer #(.SLOT_W(16), .FIFO_DEPTH(DEPTH), .DEAD_CYCLES(DEAD)) u_dut (
        .clk(clk), .rst(rst), .run(run), .symbol_in(symbol_in), .pulse_detected(pulse_detected),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level),
        .overflow_cnt(overflow_cnt), .slot_count(slot_count)
    );

    reciever_event_packer #(.SLOT_W(4), .FIFO_DEPTH(DEPTH), .DEAD_CYCLES(DEAD)) u_dut4 (
        .clk(clk), .rst(rst), .run(run), .symbol_in(symbol_in), .pulse_detected(pulse_detected),
        .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready), .fifo_level(fifo_level4),
        .overflow_cnt(overflow_cnt4), .slot_count(slot_count4)
    );

    function automatic logic [17:0] exp_data();
        return (mq.size() != 0) ? mq[0] : 18'd0;
    endfunction

    // Advance the reference model by one clock using the current inputs, then clock the DUTs
    task automatic cyc();
        bit          pop;
        bit          ev;
        logic [17:0] rec;
        if (rst) begin
            mq.delete();
            m_slot     = '0;
            m_run_hist = 1'b0;
            m_ovf      = 0;
            m_dead     = 0;
        end else begin
            pop = (mq.size() != 0) && m_ready;
            ev  = run && pulse_detected;
`ifdef DEAD_TIME_EN
            if (m_dead != 0) ev = 1'b0;
`endif
            rec = {m_slot, symbol_in};
            if (pop) void'(mq.pop_front());
            if (ev) begin
                if (mq.size() < DEPTH) mq.push_back(rec);
                else if (m_ovf < 65535) m_ovf++;
            end
`ifdef DEAD_TIME_EN
            if (!run) m_dead = 0;
            else if (ev) m_dead = DEAD;
            else if (m_dead > 0) m_dead--;
`endif
            if (run && !m_run_hist) m_slot = '0;
            else if (run) m_slot = m_slot + 16'd1;
            m_run_hist = run;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; pulse_detected = 1'b0; m_ready = 1'b0; symbol_in = 2'd0;
        cyc();
        rst = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_valid); end
        checks++; if (m_data !== 18'd0) begin errors++; $display("FAIL reset_data got %h want 0", m_data); end
        checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovf got %0d want 0", overflow_cnt); end
        checks++; if (slot_count !== 16'd0) begin errors++; $display("FAIL reset_slot got %0d want 0", slot_count); end
        checks++; if (m_valid4 !== 1'b0 || m_data4 !== 6'd0) begin errors++; $display("FAIL reset_dut4 got v=%b d=%h want 0", m_valid4, m_data4); end
        repeat (3) cyc();
        checks++; if (slot_count !== 16'd0) begin errors++; $display("FAIL idle_slot_hold got %0d want 0", slot_count); end
    endtask

    task automatic test_first_event();
        run = 1'b1;
        for (int i = 0; i < 20 && m_slot != 16'd5; i++) cyc();
        checks++; if (slot_count !== 16'd5) begin errors++; $display("FAIL first_slot got %0d want 5", slot_count); end
        pulse_detected = 1'b1; symbol_in = 2'b01;
        cyc();
        pulse_detected = 1'b0;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", m_valid); end
        checks++; if (m_data !== {16'd5, 2'b01}) begin errors++; $display("FAIL first_data got %h want %h", m_data, {16'd5, 2'b01}); end
        checks++; if (m_data4 !== {4'd5, 2'b01}) begin errors++; $display("FAIL first_data4 got %h want %h", m_data4, {4'd5, 2'b01}); end
        checks++; if (fifo_level !== 5'd1) begin errors++; $display("FAIL first_level got %0d want 1", fifo_level); end
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        checks++; if (fifo_level !== 5'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL first_pop got lvl=%0d v=%b want 0/0", fifo_level, m_valid); end
    endtask

    task automatic test_overflow();
        logic [15:0] s0;
        logic [17:0] e;
        m_ready = 1'b0; pulse_detected = 1'b1;
        s0 = m_slot;
        for (int i = 0; i < 18; i++) begin
            symbol_in = 2'($urandom);
            cyc();
        end
        pulse_detected = 1'b0;
        checks++; if (fifo_level !== 5'(mq.size())) begin errors++; $display("FAIL ovf_level got %0d want %0d", fifo_level, mq.size()); end
        checks++; if (overflow_cnt !== 16'(m_ovf)) begin errors++; $display("FAIL ovf_count got %0d want %0d", overflow_cnt, m_ovf); end
`ifndef DEAD_TIME_EN
        checks++; if (fifo_level !== 5'd16 || overflow_cnt !== 16'd2) begin errors++; $display("FAIL ovf_const got lvl=%0d ovf=%0d want 16/2", fifo_level, overflow_cnt); end
`endif
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_data();
            checks++; if (m_data !== e || m_data4 !== e[5:0]) begin errors++; $display("FAIL ovf_drain[%0d] got %h/%h want %h", i, m_data, m_data4, e); end
`ifndef DEAD_TIME_EN
            checks++; if (m_data[17:2] !== s0 + 16'(i)) begin errors++; $display("FAIL ovf_order[%0d] got %0d want %0d", i, m_data[17:2], s0 + 16'(i)); end
`endif
            cyc();
        end
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", m_valid); end
    endtask

    task automatic test_full_pop();
        logic [15:0] ovf_before;
        logic [17:0] rec_new;
        logic [17:0] e;
        m_ready = 1'b0; pulse_detected = 1'b1;
        for (int i = 0; i < 200 && mq.size() < DEPTH; i++) begin
            symbol_in = 2'($urandom);
            cyc();
        end
        pulse_detected = 1'b0;
        repeat (DEAD + 1) cyc();
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_fill got %0d want 16", fifo_level); end
        ovf_before = overflow_cnt;
        rec_new = {m_slot, 2'b10};
        pulse_detected = 1'b1; symbol_in = 2'b10; m_ready = 1'b1;
        cyc();
        pulse_detected = 1'b0; m_ready = 1'b0;
        checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_pop_level got %0d want 16", fifo_level); end
        checks++; if (overflow_cnt !== ovf_before) begin errors++; $display("FAIL full_pop_ovf got %0d want %0d", overflow_cnt, ovf_before); end
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_data();
            checks++; if (m_data !== e) begin errors++; $display("FAIL full_drain[%0d] got %h want %h", i, m_data, e); end
            if (i == DEPTH - 1) begin
                checks++; if (m_data !== rec_new) begin errors++; $display("FAIL full_new_last got %h want %h", m_data, rec_new); end
            end
            cyc();
        end
        m_ready = 1'b0;
    endtask

    task automatic test_wrap();
        run = 1'b0; cyc();
        run = 1'b1; m_ready = 1'b0;
        for (int i = 0; i < 25; i++) begin
            pulse_detected = (m_slot == 16'd15) || (m_slot == 16'(WRAP_SECOND));
            symbol_in = 2'($urandom);
            cyc();
        end
        pulse_detected = 1'b0;
        checks++; if (fifo_level4 !== 5'd2) begin errors++; $display("FAIL wrap_level got %0d want 2", fifo_level4); end
        checks++; if (m_data4[5:2] !== 4'd15) begin errors++; $display("FAIL wrap_first got %0d want 15", m_data4[5:2]); end
        m_ready = 1'b1; cyc();
        checks++; if (m_data4[5:2] !== 4'(WRAP_SECOND % 16)) begin errors++; $display("FAIL wrap_second got %0d want %0d", m_data4[5:2], WRAP_SECOND % 16); end
        checks++; if (m_data[17:2] !== 16'(WRAP_SECOND)) begin errors++; $display("FAIL wrap_wide got %0d want %0d", m_data[17:2], WRAP_SECOND); end
        cyc();
        m_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] s0;
        int offs[$];
`ifdef DEAD_TIME_EN
        offs = '{0, 5};
`else
        offs = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
`endif
        run = 1'b0; cyc(); run = 1'b1; cyc();
        m_ready = 1'b0; pulse_detected = 1'b1;
        s0 = m_slot;
        for (int i = 0; i < 10; i++) begin
            symbol_in = 2'($urandom);
            cyc();
        end
        pulse_detected = 1'b0;
        checks++; if (fifo_level !== 5'(offs.size())) begin errors++; $display("FAIL b2b_level got %0d want %0d", fifo_level, offs.size()); end
        checks++; if (overflow_cnt !== 16'(m_ovf)) begin errors++; $display("FAIL b2b_ovf got %0d want %0d", overflow_cnt, m_ovf); end
        m_ready = 1'b1;
        foreach (offs[i]) begin
            checks++; if (m_data[17:2] !== s0 + 16'(offs[i])) begin errors++; $display("FAIL b2b_slot[%0d] got %0d want %0d", i, m_data[17:2], s0 + 16'(offs[i])); end
            cyc();
        end
        m_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [17:0] e;
        int ready_bias;
        for (int i = 0; i < 3000; i++) begin
            ready_bias     = ((i / 200) % 2 == 0) ? 3 : 1;
            rst            = ($urandom_range(0, 699) == 0);
            run            = ($urandom_range(0, 15) != 0);
            pulse_detected = ($urandom_range(0, 1) == 1);
            symbol_in      = 2'($urandom);
            m_ready        = ($urandom_range(0, 3) < ready_bias);
            cyc();
            rst = 1'b0;
            e = exp_data();
            checks++; if (m_valid !== (mq.size() != 0) || m_data !== e) begin errors++; $display("FAIL rnd_data[%0d] got v=%b d=%h want v=%b d=%h", i, m_valid, m_data, mq.size() != 0, e); end
            checks++; if (fifo_level !== 5'(mq.size()) || overflow_cnt !== 16'(m_ovf)) begin errors++; $display("FAIL rnd_level[%0d] got lvl=%0d ovf=%0d want %0d/%0d", i, fifo_level, overflow_cnt, mq.size(), m_ovf); end
            checks++; if (slot_count !== m_slot || slot_count4 !== m_slot[3:0]) begin errors++; $display("FAIL rnd_slot[%0d] got %0d/%0d want %0d", i, slot_count, slot_count4, m_slot); end
            checks++; if (m_data4 !== e[5:0]) begin errors++; $display("FAIL rnd_data4[%0d] got %h want %h", i, m_data4, e[5:0]); end
        end
        run = 1'b0; pulse_detected = 1'b0; m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_overflow();
        test_full_pop();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
